// File: rtl/l1_assoc_cache.sv
// Set-associative L1 data cache with true-LRU replacement, write-back / write-allocate,
// and a single outstanding line request to L2. Accepts only addresses tagged with PROC_ID.
module l1_assoc_cache #(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int SETS           = 16,
  parameter int WAYS           = 2,
  parameter int PROC_ID_W      = 2,
  parameter int PROC_ID        = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  input  logic                             req_write,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic [WORD_W-1:0]                req_wdata,
  output logic                             req_ready,
  output logic                             resp_valid,
  output logic                             resp_hit,
  output logic [WORD_W-1:0]                resp_rdata,
  output logic                             l2_req_valid,
  output logic                             l2_req_write,
  output logic [ADDR_W-1:0]                l2_req_addr,
  output logic [WORD_W*WORDS_PER_LINE-1:0] l2_wline,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] l2_rline,
  input  logic                             l2_done,
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count
);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - PROC_ID_W - IDX_W - OFF_W;
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
  state_t state_reg;

  logic [ADDR_W-1:0] addr_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic              write_reg;
  logic              first_reg;
  logic [WAY_W-1:0]  victim_reg;

  logic [WAYS-1:0]   valid_reg [SETS];
  logic [WAYS-1:0]   dirty_reg [SETS];
  logic [WAY_W-1:0]  age_reg   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
  logic [LINE_W-1:0] data_mem  [SETS][WAYS];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WAYS-1:0]   way_hit;
  logic              hit;
  logic [WAY_W-1:0]  hit_way, victim_way, best_age, touch_way;
  logic [LINE_W-1:0] hit_line;
  logic [WORD_W-1:0] hit_word;
  logic              touch_en, fill_en;
  logic [ADDR_W-1:0] refill_addr;

  assign off = addr_reg[OFF_W-1:0];
  assign idx = addr_reg[OFF_W +: IDX_W];
  assign tag = addr_reg[OFF_W+IDX_W +: TAG_W];
  assign refill_addr = {addr_reg[ADDR_W-1:OFF_W], OFF_W'(0)};

  assign req_ready = !reset && (state_reg == IDLE) &&
                     (req_addr[ADDR_W-1 -: PROC_ID_W] == PROC_ID_W'(PROC_ID));

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
      assign way_hit[gi] = valid_reg[idx][gi] && (tag_mem[idx][gi] == tag);
    end
  endgenerate

  always_comb begin
    hit        = |way_hit;
    hit_way    = '0;
    best_age   = '0;
    victim_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (way_hit[w]) hit_way = WAY_W'(w);
    // Oldest way first, then any invalid way overrides (lowest index wins).
    for (int w = 0; w < WAYS; w++)
      if (age_reg[idx][w] > best_age) begin
        best_age   = age_reg[idx][w];
        victim_way = WAY_W'(w);
      end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_reg[idx][w]) victim_way = WAY_W'(w);
  end

  assign hit_line  = data_mem[idx][hit_way];
  assign hit_word  = hit_line[int'(off)*WORD_W +: WORD_W];
  assign fill_en   = (state_reg == REFILL) && l2_done;
  assign touch_en  = ((state_reg == LOOKUP) && hit) || fill_en;
  assign touch_way = (state_reg == LOOKUP) ? hit_way : victim_reg;

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_mem[idx][victim_reg] <= l2_rline;
      tag_mem[idx][victim_reg]  <= tag;
    end else if ((state_reg == LOOKUP) && hit && write_reg) begin
      data_mem[idx][hit_way][int'(off)*WORD_W +: WORD_W] <= wdata_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      write_reg    <= 1'b0;
      first_reg    <= 1'b0;
      victim_reg   <= '0;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_rdata   <= '0;
      l2_req_valid <= 1'b0;
      l2_req_write <= 1'b0;
      l2_req_addr  <= '0;
      l2_wline     <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_reg[s][w] <= '0;
      end
    end else begin
      // Accessed way becomes youngest; ways no older than it age by one.
      if (touch_en)
        for (int w = 0; w < WAYS; w++)
          if (WAY_W'(w) == touch_way)
            age_reg[idx][w] <= '0;
          else if ((age_reg[idx][w] <= age_reg[idx][touch_way]) && (age_reg[idx][w] != AGE_MAX))
            age_reg[idx][w] <= age_reg[idx][w] + 1'b1;

      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            write_reg <= req_write;
            first_reg <= 1'b1;
            state_reg <= LOOKUP;
          end
        end
        LOOKUP: begin
          first_reg <= 1'b0;
          if (first_reg) begin
            if (hit && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 1;
            if (!hit && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 1;
          end
          if (hit) begin
            if (write_reg) dirty_reg[idx][hit_way] <= 1'b1;
            resp_valid <= 1'b1;
            resp_hit   <= first_reg;
            resp_rdata <= hit_word;
            state_reg  <= RESPOND;
          end else begin
            victim_reg   <= victim_way;
            l2_req_valid <= 1'b1;
            if (valid_reg[idx][victim_way] && dirty_reg[idx][victim_way]) begin
              l2_req_write <= 1'b1;
              l2_req_addr  <= {PROC_ID_W'(PROC_ID), tag_mem[idx][victim_way], idx, OFF_W'(0)};
              l2_wline     <= data_mem[idx][victim_way];
              state_reg    <= WRITEBACK;
            end else begin
              l2_req_write <= 1'b0;
              l2_req_addr  <= refill_addr;
              state_reg    <= REFILL;
            end
          end
        end
        WRITEBACK: begin
          if (l2_done) begin
            dirty_reg[idx][victim_reg] <= 1'b0;
            l2_req_write <= 1'b0;
            l2_req_addr  <= refill_addr;
            state_reg    <= REFILL;
          end
        end
        REFILL: begin
          if (l2_done) begin
            valid_reg[idx][victim_reg] <= 1'b1;
            dirty_reg[idx][victim_reg] <= 1'b0;
            l2_req_valid <= 1'b0;
            state_reg    <= LOOKUP;
          end
        end
        RESPOND: begin
          resp_valid <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_assoc_cache.sv
// Directed bench for l1_assoc_cache at default parameters (2 ways, 16 sets, 4-word lines);
// addresses 0x40/0x80/0xC0/0x100 all map to set 0 with tags 1/2/3/4.
module tb_l1_assoc_cache;
  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_write;
  logic [31:0]  req_addr, req_wdata;
  logic         req_ready;
  logic         resp_valid, resp_hit;
  logic [31:0]  resp_rdata;
  logic         l2_req_valid, l2_req_write;
  logic [31:0]  l2_req_addr;
  logic [127:0] l2_wline, l2_rline;
  logic         l2_done;
  logic [31:0]  hit_count, miss_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc;

  always #5 clk = ~clk;

  l1_assoc_cache dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .l2_req_valid(l2_req_valid), .l2_req_write(l2_req_write), .l2_req_addr(l2_req_addr),
    .l2_wline(l2_wline), .l2_rline(l2_rline), .l2_done(l2_done),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_line(input logic [31:0] w3, w2, w1, w0);
    return {w3, w2, w1, w0};
  endfunction

  // Present one request in a cycle and let it be accepted at the next posedge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    #1 check("req_ready_accept", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_l2();
    int n;
    n = 0;
    @(negedge clk);
    while (!l2_req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("l2_req_seen", l2_req_valid, 1'b1);
  endtask

  task automatic reply(input logic [127:0] line);
    @(negedge clk);
    l2_rline = line; l2_done = 1'b1;
    @(posedge clk);
    #1 l2_done = 1'b0;
  endtask

  // cyc counts clock cycles with the accept cycle as cycle 1.
  task automatic wait_resp(output int c);
    c = 1;
    do begin
      @(negedge clk);
      c++;
    end while (!resp_valid && c < 60);
    check("resp_seen", resp_valid, 1'b1);
  endtask

  task automatic resp_gone();
    @(negedge clk);
    check("resp_one_cycle", resp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    l2_rline = '0; l2_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_l2_req_valid", l2_req_valid, 1'b0);
    check("rst_l2_req_addr", l2_req_addr, 32'h0);
    check("rst_l2_wline", l2_wline, 128'h0);
    check("rst_hit_count", hit_count, 32'h0);
    check("rst_miss_count", miss_count, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1'b1);

    // Cold read miss of 0x40.
    issue(1'b0, 32'h40, 32'h0);
    wait_l2();
    check("rd40_l2_write", l2_req_write, 1'b0);
    check("rd40_l2_addr", l2_req_addr, 32'h40);
    reply(mk_line(32'd4, 32'd3, 32'd2, 32'd1));
    wait_resp(cyc);
    check("rd40_rdata", resp_rdata, 32'd1);
    check("rd40_hit", resp_hit, 1'b0);
    check("rd40_miss_count", miss_count, 32'd1);
    resp_gone();

    // Read hit of 0x41 responds in the third cycle counting the accept cycle.
    issue(1'b0, 32'h41, 32'h0);
    wait_resp(cyc);
    check("rd41_latency", cyc, 3);
    check("rd41_rdata", resp_rdata, 32'd2);
    check("rd41_hit", resp_hit, 1'b1);
    check("rd41_hit_count", hit_count, 32'd1);
    check("rd41_l2_idle", l2_req_valid, 1'b0);
    resp_gone();

    // Write hit dirties way 0.
    issue(1'b1, 32'h40, 32'hDEAD);
    wait_resp(cyc);
    check("wr40_hit", resp_hit, 1'b1);
    check("wr40_hit_count", hit_count, 32'd2);
    resp_gone();

    // Read 0x80 fills the invalid way 1 with no write-back.
    issue(1'b0, 32'h80, 32'h0);
    wait_l2();
    check("rd80_l2_write", l2_req_write, 1'b0);
    check("rd80_l2_addr", l2_req_addr, 32'h80);
    reply(mk_line(32'h84, 32'h83, 32'h82, 32'h81));
    wait_resp(cyc);
    check("rd80_rdata", resp_rdata, 32'h81);
    check("rd80_hit", resp_hit, 1'b0);
    resp_gone();

    // Read 0xC0 evicts LRU way 0 (dirty 0x40 line) through write-back.
    issue(1'b0, 32'hC0, 32'h0);
    wait_l2();
    check("wb_l2_write", l2_req_write, 1'b1);
    check("wb_l2_addr", l2_req_addr, 32'h40);
    check("wb_l2_wline", l2_wline, mk_line(32'd4, 32'd3, 32'd2, 32'hDEAD));
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h80;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_req_ready", req_ready, 1'b0);
      check("stall_l2_valid", l2_req_valid, 1'b1);
      check("stall_l2_write", l2_req_write, 1'b1);
      check("stall_l2_addr", l2_req_addr, 32'h40);
    end
    req_valid = 1'b0;
    reply(mk_line(32'hBAD3, 32'hBAD2, 32'hBAD1, 32'hBAD0));
    @(negedge clk);
    check("rfC0_l2_valid", l2_req_valid, 1'b1);
    check("rfC0_l2_write", l2_req_write, 1'b0);
    check("rfC0_l2_addr", l2_req_addr, 32'hC0);
    reply(mk_line(32'hC4, 32'hC3, 32'hC2, 32'hC1));
    wait_resp(cyc);
    check("rdC0_rdata", resp_rdata, 32'hC1);
    check("rdC0_hit", resp_hit, 1'b0);
    check("rdC0_miss_count", miss_count, 32'd3);
    resp_gone();

    // 0x80 survived in way 1.
    issue(1'b0, 32'h82, 32'h0);
    wait_resp(cyc);
    check("rd82_rdata", resp_rdata, 32'h83);
    check("rd82_hit", resp_hit, 1'b1);
    check("rd82_hit_count", hit_count, 32'd3);
    resp_gone();

    // Request for processor ID 1 is never accepted.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4000_0040;
    for (int i = 0; i < 5; i++) begin
      #1 check("foreign_req_ready", req_ready, 1'b0);
      check("foreign_l2_valid", l2_req_valid, 1'b0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("foreign_resp_valid", resp_valid, 1'b0);
    check("foreign_hit_count", hit_count, 32'd3);
    check("foreign_miss_count", miss_count, 32'd3);

    // A stray l2_done in IDLE changes nothing.
    reply(mk_line(32'h1, 32'h2, 32'h3, 32'h4));
    @(negedge clk);
    req_addr = 32'h40;
    #1 check("stray_done_ready", req_ready, 1'b1);
    check("stray_done_l2_valid", l2_req_valid, 1'b0);
    check("stray_done_resp", resp_valid, 1'b0);

    // Reset while REFILL waits on L2.
    issue(1'b0, 32'h100, 32'h0);
    wait_l2();
    check("rf100_l2_addr", l2_req_addr, 32'h100);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_l2_valid", l2_req_valid, 1'b0);
    check("midrst_l2_addr", l2_req_addr, 32'h0);
    check("midrst_miss_count", miss_count, 32'h0);
    reset = 1'b0;
    issue(1'b0, 32'h40, 32'h0);
    wait_l2();
    check("post_rst_l2_write", l2_req_write, 1'b0);
    check("post_rst_l2_addr", l2_req_addr, 32'h40);
    reply(mk_line(32'h14, 32'h13, 32'h12, 32'h11));
    wait_resp(cyc);
    check("post_rst_hit", resp_hit, 1'b0);
    check("post_rst_rdata", resp_rdata, 32'h11);
    check("post_rst_miss_count", miss_count, 32'd1);
    resp_gone();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
